// File: rtl/opa_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : opa_arbiter_if
// Brief    : Request/grant/status bundle between operand-A requesters and arbiter.
// Revision : 1.0
// ============================================================================
interface opa_arbiter_if #(
  parameter int XCNT_W = 16
) ();
  logic              fwd_req;
  logic              reg_req;
  logic              stall;
  logic              fwd_gnt;
  logic              reg_gnt;
  logic              sel;
  logic              a_valid;
  logic              a_src;
  logic [XCNT_W-1:0] fwd_xfers;
  logic [XCNT_W-1:0] reg_xfers;

  modport master (
    input  fwd_req, reg_req, stall,
    output fwd_gnt, reg_gnt, sel, a_valid, a_src, fwd_xfers, reg_xfers
  );

  modport slave (
    output fwd_req, reg_req, stall,
    input  fwd_gnt, reg_gnt, sel, a_valid, a_src, fwd_xfers, reg_xfers
  );
endinterface
`default_nettype wire

// File: rtl/opa_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : opa_arbiter
// Brief    : Operand-A mux arbiter (FWD vs REG), burst-limited round robin.
//            Define OPA_ARB_FIXED_PRIO_EN for fixed FWD-over-REG priority.
// Revision : 1.0
// ============================================================================
module opa_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3,
  parameter int XCNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  opa_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_G_FWD = 2'd1,
    S_G_REG = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  c_max_burst = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  c_one       = CNT_W'(1);
  localparam logic [XCNT_W-1:0] c_xone      = XCNT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_burst;
  logic [CNT_W-1:0]  w_burst_nxt;
  logic [CNT_W-1:0]  w_burst_inc;
  logic              r_last_fwd;
  logic              r_fwd_gnt;
  logic              r_reg_gnt;
  logic              r_sel;
  logic              w_sel_nxt;
  logic              r_a_valid;
  logic              r_a_src;
  logic [XCNT_W-1:0] r_fwd_xfers;
  logic [XCNT_W-1:0] r_reg_xfers;
  logic              w_fwd_xfer;
  logic              w_reg_xfer;
  logic              w_xfer;

  assign w_fwd_xfer = r_fwd_gnt & bus.fwd_req & ~bus.stall;
  assign w_reg_xfer = r_reg_gnt & bus.reg_req & ~bus.stall;
  assign w_xfer     = w_fwd_xfer | w_reg_xfer;

  // Clamped so a long uncontested tenure cannot wrap the counter.
  assign w_burst_inc = (r_burst >= c_max_burst) ? r_burst : r_burst + c_one;

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_sel_nxt   = r_sel;
    if (!bus.stall) begin
      unique case ({bus.fwd_req, bus.reg_req})
        2'b00: w_state_nxt = S_IDLE;
        2'b10: w_state_nxt = S_G_FWD;
        2'b01: w_state_nxt = S_G_REG;
        default: begin
`ifdef OPA_ARB_FIXED_PRIO_EN
          w_state_nxt = S_G_FWD;
`else
          case (r_state)
            S_G_FWD: w_state_nxt = (w_burst_inc >= c_max_burst) ? S_G_REG : S_G_FWD;
            S_G_REG: w_state_nxt = (w_burst_inc >= c_max_burst) ? S_G_FWD : S_G_REG;
            default: w_state_nxt = r_last_fwd ? S_G_REG : S_G_FWD;
          endcase
`endif
        end
      endcase
      if (w_state_nxt != r_state)
        w_burst_nxt = '0;
      else if (w_xfer)
        w_burst_nxt = w_burst_inc;
    end
    if (w_state_nxt == S_G_FWD)
      w_sel_nxt = 1'b1;
    else if (w_state_nxt == S_G_REG)
      w_sel_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_burst     <= '0;
      r_last_fwd  <= 1'b0;
      r_fwd_gnt   <= 1'b0;
      r_reg_gnt   <= 1'b0;
      r_sel       <= 1'b0;
      r_a_valid   <= 1'b0;
      r_a_src     <= 1'b0;
      r_fwd_xfers <= '0;
      r_reg_xfers <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_burst   <= w_burst_nxt;
      r_fwd_gnt <= (w_state_nxt == S_G_FWD);
      r_reg_gnt <= (w_state_nxt == S_G_REG);
      r_sel     <= w_sel_nxt;
      // Mux captures with the current sel at this edge, so tag the data with it.
      r_a_valid <= w_xfer;
      if (w_xfer)
        r_a_src <= r_sel;
      if (w_fwd_xfer) begin
        r_fwd_xfers <= r_fwd_xfers + c_xone;
        r_last_fwd  <= 1'b1;
      end
      if (w_reg_xfer) begin
        r_reg_xfers <= r_reg_xfers + c_xone;
        r_last_fwd  <= 1'b0;
      end
    end
  end

  assign bus.fwd_gnt   = r_fwd_gnt;
  assign bus.reg_gnt   = r_reg_gnt;
  assign bus.sel       = r_sel;
  assign bus.a_valid   = r_a_valid;
  assign bus.a_src     = r_a_src;
  assign bus.fwd_xfers = r_fwd_xfers;
  assign bus.reg_xfers = r_reg_xfers;

endmodule
`default_nettype wire

// File: doc/opa_arbiter.md
Name: opa_arbiter

Overview:
- Shares the registered operand-A mux (32-bit forwarded result path vs. 16-bit zero-extended register-read path) between two requesters.
- Requester FWD (mux sel=1) is the writeback forwarding path; requester REG (mux sel=0) is the register-file read port.
- Drives the mux select, issues grants with burst limiting and round-robin fairness, and flags when the mux output holds valid data and which source produced it.
- Sits between the decode/forwarding logic and the ALU operand-A input.

Parameters:
MAX_BURST, 4, max consecutive transfers granted to one requester while the other is requesting (range 1..2^CNT_W-1)
CNT_W, 3, width of the burst counter
XCNT_W, 16, width of the per-source transfer counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
fwd_req  input  1  FWD requests one operand transfer per cycle held
reg_req  input  1  REG requests one operand transfer per cycle held
stall  input  1  ALU not ready; freeze all transfers
fwd_gnt  output  1  registered grant to FWD
reg_gnt  output  1  registered grant to REG
sel  output  1  to mux sel; 1=FWD, 0=REG
a_valid  output  1  mux output valid this cycle
a_src  output  1  source of the valid mux output (1=FWD)
fwd_xfers  output  XCNT_W  count of completed FWD transfers
reg_xfers  output  XCNT_W  count of completed REG transfers

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: fwd_gnt=0, reg_gnt=0, sel=0, a_valid=0, a_src=0, fwd_xfers=0, reg_xfers=0, burst counter=0, last-served=REG (so FWD wins the first tie), state=IDLE.
- States:
  - IDLE: no grant.
  - G_FWD: fwd_gnt=1, sel=1.
  - G_REG: reg_gnt=1, sel=0.
- Grant and sel are registered together, so sel is stable for the whole grant cycle.
- Transfer: xfer = gnt & req & !stall, sampled at a rising edge.
  - At that edge the mux captures with sel.
  - a_valid<=1 and a_src<=sel at the same edge, so valid aligns with mux output.
  - Latency from req to a_valid: 2 cycles.
  - a_valid<=0 on any edge without xfer.
- Transitions, evaluated each edge with !stall:
  - No request -> IDLE, burst counter cleared.
  - One requester -> grant it; no burst limit applies.
  - Both requesting from IDLE -> grant the one not last served.
  - Both requesting while granted -> keep the current grant until the burst counter reaches MAX_BURST, then switch to the other and clear the counter.
  - Granted requester drops req -> switch to the other if it requests, else IDLE.
- Burst counter increments on each xfer of the current owner; cleared on owner change.
- stall=1:
  - state, sel, counters and last-served are frozen.
  - gnt outputs keep their value but no xfer occurs.
  - a_valid<=0.
- Requester must hold req until it sees gnt. A req dropped in the grant cycle completes no transfer and is not counted.
- Transfer counters increment by 1 per xfer of their source and wrap at 2^XCNT_W-1 -> 0 without saturation.
- Only one gnt is ever high; sel equals fwd_gnt whenever either gnt is high. In IDLE, sel holds its last value.
- Reset mid-burst: all outputs return to reset values immediately (asynchronously). An in-flight a_valid is dropped.

Optional Feature:
- Macro OPA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; FWD always wins contention; MAX_BURST and last-served are ignored; REG is granted only when fwd_req=0.
- Undefined: round-robin with MAX_BURST limiting, as above.

Test Plan:
- Reset with fwd_req=reg_req=1, release rst_n -> 1 cycle later fwd_gnt=1, sel=1; next cycle a_valid=1, a_src=1, fwd_xfers=1.
- Both held high, MAX_BURST=4 -> grant pattern FWD×4, REG×4, FWD×4; both counters reach 8 after 16 transfers.
- Only reg_req held for 10 cycles -> reg_gnt continuous, sel=0, reg_xfers=9 after 10 grant edges, fwd_gnt never asserted.
- stall=1 for 3 cycles mid-burst -> a_valid=0 for those 3 cycles; sel and gnt unchanged; burst resumes at the same count after stall drops.
- Preload reg_xfers to 0xFFFF via transfers, one more REG transfer -> reg_xfers=0x0000.
- Assert rst_n=0 asynchronously between edges during G_FWD -> fwd_gnt, a_valid, sel go to 0 before the next clk edge.
- With OPA_ARB_FIXED_PRIO_EN defined and both requests held 12 cycles -> reg_gnt never asserted.
